// File: rtl/alu_issue_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_issue_if
// Description : Request, ALU-facing and result signal bundle for alu_issue.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      in_opcode;
    logic [2:0]      in_funct3;
    logic            in_funct7b5;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [XLEN-1:0] in_imm;
    logic [4:0]      in_rd;

    logic [2:0]      aluop;
    logic            aluctr;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;
    logic [4:0]      out_rd;
    logic            out_zero;
    logic            out_illegal;

    // The environment side: decode stage, ALU and writeback consumer.
    modport master (
        output in_valid, in_opcode, in_funct3, in_funct7b5,
               in_rs1, in_rs2, in_imm, in_rd,
               alu_result, alu_zero, out_ready,
        input  in_ready, aluop, aluctr, alu_a, alu_b,
               out_valid, out_data, out_rd, out_zero, out_illegal
    );

    modport slave (
        input  in_valid, in_opcode, in_funct3, in_funct7b5,
               in_rs1, in_rs2, in_imm, in_rd,
               alu_result, alu_zero, out_ready,
        output in_ready, aluop, aluctr, alu_a, alu_b,
               out_valid, out_data, out_rd, out_zero, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_issue
// Description : Two-stage issue/writeback pipeline around a combinational ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    alu_issue_if.slave            bus,
    output logic [CNT_W-1:0]      op_count
);
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [2:0] c_aluop_passb = 3'd3;

    // Decode
    logic            w_illegal;
    logic [2:0]      w_aluop;
    logic            w_aluctr;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;

    // Pipeline control
    logic w_s2_free;
    logic w_s1_adv;
    logic w_in_ready;
    logic w_accept;

    // Stage S1
    logic            r_s1_valid;
    logic [4:0]      r_s1_rd;
    logic            r_s1_illegal;
    logic [2:0]      r_aluop;
    logic            r_aluctr;
    logic [XLEN-1:0] r_alu_a;
    logic [XLEN-1:0] r_alu_b;

    // Stage S2
    logic            r_out_valid;
    logic [XLEN-1:0] r_out_data;
    logic [4:0]      r_out_rd;
    logic            r_out_zero;
    logic            r_out_illegal;

    logic [CNT_W-1:0] r_op_count;

    always_comb begin
        w_illegal = 1'b1;
        w_aluop   = 3'd0;
        w_aluctr  = 1'b0;
        w_a       = '0;
        w_b       = '0;
        case (bus.in_opcode)
            c_opc_op, c_opc_op_imm: begin
                // funct3 = 3 (unsigned compare) has no ALU implementation.
                if (bus.in_funct3 != 3'd3) begin
                    w_illegal = 1'b0;
                    w_aluop   = bus.in_funct3;
                    w_a       = bus.in_rs1;
                    w_b       = (bus.in_opcode == c_opc_op) ? bus.in_rs2 : bus.in_imm;
                    case (bus.in_funct3)
                        3'd0:    w_aluctr = (bus.in_opcode == c_opc_op) ? bus.in_funct7b5 : 1'b0;
                        3'd5:    w_aluctr = bus.in_funct7b5;
                        3'd2:    w_aluctr = 1'b1;
                        default: w_aluctr = 1'b0;
                    endcase
                end
            end
            c_opc_lui: begin
                w_illegal = 1'b0;
                w_aluop   = c_aluop_passb;
                w_b       = bus.in_imm;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_s2_free  = ~r_out_valid | bus.out_ready;
    assign w_s1_adv   = r_s1_valid & w_s2_free;
    assign w_in_ready = ~r_s1_valid | w_s2_free;
    assign w_accept   = bus.in_valid & w_in_ready;

    // Issue register: ALU-facing fields only change on an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_rd      <= 5'd0;
            r_s1_illegal <= 1'b0;
            r_aluop      <= 3'd0;
            r_aluctr     <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
        end else if (w_accept) begin
            r_s1_valid   <= 1'b1;
            r_s1_rd      <= bus.in_rd;
            r_s1_illegal <= w_illegal;
            r_aluop      <= w_aluop;
            r_aluctr     <= w_aluctr;
            r_alu_a      <= w_a;
            r_alu_b      <= w_b;
        end else if (w_s1_adv) begin
            r_s1_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_rd      <= 5'd0;
            r_out_zero    <= 1'b0;
            r_out_illegal <= 1'b0;
        end else if (w_s1_adv) begin
            r_out_valid   <= 1'b1;
            r_out_data    <= r_s1_illegal ? '0 : bus.alu_result;
            r_out_rd      <= r_s1_rd;
            r_out_zero    <= r_s1_illegal ? 1'b0 : bus.alu_zero;
            r_out_illegal <= r_s1_illegal;
        end else if (r_out_valid & bus.out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_accept) begin
            r_op_count <= r_op_count + 1'b1;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.aluop       = r_aluop;
    assign bus.aluctr      = r_aluctr;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.out_rd      = r_out_rd;
    assign bus.out_zero    = r_out_zero;
    assign bus.out_illegal = r_out_illegal;
    assign op_count        = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue
// Description : Scoreboard bench for alu_issue with a behavioural ALU model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue;
    localparam logic [6:0] c_op     = 7'b0110011;
    localparam logic [6:0] c_op_imm = 7'b0010011;
    localparam logic [6:0] c_lui    = 7'b0110111;
    localparam int         c_budget = 50;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        zero;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] op_count;
    logic [31:0] r_alu_res;
    exp_t        q[$];
    int          total;
    int          bad;

    alu_issue_if #(.XLEN(32)) bus ();

    alu_issue #(.XLEN(32), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU on the far side of the operand interface.
    always_comb begin
        r_alu_res = 32'd0;
        case (bus.aluop)
            3'd0: r_alu_res = bus.aluctr ? bus.alu_a - bus.alu_b : bus.alu_a + bus.alu_b;
            3'd1: r_alu_res = bus.alu_a << bus.alu_b[4:0];
            3'd2: r_alu_res = {31'd0, ($signed(bus.alu_a) < $signed(bus.alu_b))};
            3'd3: r_alu_res = bus.alu_b;
            3'd4: r_alu_res = bus.alu_a ^ bus.alu_b;
            3'd5: r_alu_res = bus.aluctr ? 32'($signed(bus.alu_a) >>> bus.alu_b[4:0])
                                         : bus.alu_a >> bus.alu_b[4:0];
            3'd6: r_alu_res = bus.alu_a | bus.alu_b;
            default: r_alu_res = bus.alu_a & bus.alu_b;
        endcase
    end
    assign bus.alu_result = r_alu_res;
    assign bus.alu_zero   = (r_alu_res == 32'd0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer is committed at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got rd=%0d data=0x%08h with empty queue", bus.out_rd, bus.out_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_data", bus.out_data, e.data);
                chk("out_rd", 32'(bus.out_rd), 32'(e.rd));
                chk("out_zero", 32'(bus.out_zero), 32'(e.zero));
                chk("out_illegal", 32'(bus.out_illegal), 32'(e.ill));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic b5,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic [4:0] rd, input logic [31:0] ed, input logic eil);
        int   n;
        exp_t e;
        bus.in_valid    = 1'b1;
        bus.in_opcode   = op;
        bus.in_funct3   = f3;
        bus.in_funct7b5 = b5;
        bus.in_rs1      = rs1;
        bus.in_rs2      = rs2;
        bus.in_imm      = imm;
        bus.in_rd       = rd;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > c_budget) break;
        end
        if (n > c_budget) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected 1", n);
        end else begin
            e.data = ed;
            e.rd   = rd;
            e.ill  = eil;
            e.zero = !eil && (ed == 32'd0);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < c_budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic alu_ports(input string name, input logic [2:0] op, input logic ctr,
                             input logic [31:0] a, input logic [31:0] b);
        chk({name, "_aluop"}, 32'(bus.aluop), 32'(op));
        chk({name, "_aluctr"}, 32'(bus.aluctr), 32'(ctr));
        chk({name, "_alu_a"}, bus.alu_a, a);
        chk({name, "_alu_b"}, bus.alu_b, b);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] c0;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_opcode = 7'd0;
        bus.in_funct3 = 3'd0;
        bus.in_funct7b5 = 1'b0;
        bus.in_rs1 = 32'd0;
        bus.in_rs2 = 32'd0;
        bus.in_imm = 32'd0;
        bus.in_rd = 5'd0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        alu_ports("rst", 3'd0, 1'b0, 32'd0, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Basic operations
        send(c_op, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd1, 32'd12, 1'b0);
        alu_ports("add", 3'd0, 1'b0, 32'd5, 32'd7);
        chk("add_op_count", 32'(op_count), 32'd1);
        send(c_op, 3'd0, 1'b1, 32'h1234, 32'h1234, 32'd0, 5'd2, 32'd0, 1'b0);
        alu_ports("sub", 3'd0, 1'b1, 32'h1234, 32'h1234);
        send(c_op, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd3, 32'd1, 1'b0);
        alu_ports("slt", 3'd2, 1'b1, 32'hFFFF_FFFF, 32'd1);
        send(c_lui, 3'd5, 1'b1, 32'h55, 32'h66, 32'hABCD_E000, 5'd4, 32'hABCD_E000, 1'b0);
        alu_ports("lui", 3'd3, 1'b0, 32'd0, 32'hABCD_E000);
        send(c_op_imm, 3'd0, 1'b1, 32'd10, 32'd3, 32'hFFFF_FFFF, 5'd5, 32'd9, 1'b0);
        alu_ports("addi", 3'd0, 1'b0, 32'd10, 32'hFFFF_FFFF);
        send(c_op_imm, 3'd5, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 5'd6, 32'hF800_0000, 1'b0);
        alu_ports("srai", 3'd5, 1'b1, 32'h8000_0000, 32'd4);
        send(c_op, 3'd5, 1'b0, 32'h8000_0000, 32'd31, 32'd0, 5'd7, 32'd1, 1'b0);
        send(c_op, 3'd4, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 5'd8, 32'h0000_FF00, 1'b0);
        alu_ports("xor", 3'd4, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0);
        drain();

        // Illegal requests still flow through with zeroed results
        c0 = op_count;
        send(7'h63, 3'd0, 1'b0, 32'd9, 32'd9, 32'd9, 5'd9, 32'd0, 1'b1);
        alu_ports("ill_branch", 3'd0, 1'b0, 32'd0, 32'd0);
        send(c_op, 3'd3, 1'b0, 32'd3, 32'd5, 32'd0, 5'd10, 32'd0, 1'b1);
        chk("ill_op_count", 32'(op_count), 32'(c0 + 16'd2));
        drain();

        // Backpressure: four adds against a stalled consumer
        bus.out_ready = 1'b0;
        fork
            begin
                send(c_op, 3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 5'd11, 32'd2, 1'b0);
                send(c_op, 3'd0, 1'b0, 32'd2, 32'd2, 32'd0, 5'd12, 32'd4, 1'b0);
                send(c_op, 3'd0, 1'b0, 32'd3, 32'd3, 32'd0, 5'd13, 32'd6, 1'b0);
                send(c_op, 3'd0, 1'b0, 32'd4, 32'd4, 32'd0, 5'd14, 32'd8, 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
                    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
                    chk("bp_out_data", bus.out_data, 32'd2);
                    chk("bp_out_rd", 32'(bus.out_rd), 32'd11);
                    chk("bp_alu_a", bus.alu_a, 32'd2);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with both stages full
        bus.out_ready = 1'b0;
        send(c_op, 3'd0, 1'b0, 32'd20, 32'd1, 32'd0, 5'd15, 32'd21, 1'b0);
        send(c_op, 3'd0, 1'b0, 32'd30, 32'd1, 32'd0, 5'd16, 32'd31, 1'b0);
        chk("full_out_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_alu_a", bus.alu_a, 32'd0);
        chk("midrst_op_count", 32'(op_count), 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("postrst_no_pulse", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Counter wrap
        for (int i = 0; i < 65535; i++) begin
            send(c_op, 3'd0, 1'b0, 32'(i), 32'd1, 32'd0, 5'(i), 32'(i + 1), 1'b0);
        end
        chk("wrap_count_max", 32'(op_count), 32'h0000_FFFF);
        send(c_op, 3'd6, 1'b0, 32'h00F0, 32'h000F, 32'd0, 5'd31, 32'h00FF, 1'b0);
        chk("wrap_count_zero", 32'(op_count), 32'd0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
